rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Parametrised N-to-1 data multiplexer with a registered output stage and valid/ready handshaking on every channel. It extends the plain select-driven mux with two arbitration modes: round-robin across requesting channels, or a fixed select that behaves like the classic mux. It sits between multiple producers (for example, register-file read ports or memory/ALU result sources) and a single consumer in the datapath, and delivers at most one word per cycle.

## Interface
- WIDTH, 64, data width of each channel and of the output.
- N, 4, number of input channels; a power of two and at least 2.
- SELW, $clog2(N), width of the channel index (derived; do not override).

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the clk rising edge.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request; bit i means in_data channel i holds a word.
- in_ready  output  N  per-channel accept (combinational); at most one bit is high.
- mode  input  1  0 = round-robin, 1 = fixed select.
- fixed_sel  input  SELW  channel used when mode=1.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  out_data holds an undelivered word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- **State.** The block holds an output register (out_data, out_sel, out_valid) and a round-robin pointer, ptr (SELW bits).
- **Accept condition.** accept = !out_valid || out_ready. The output register loads whenever it is empty or is being drained in the same cycle.
- **Round-robin grant (mode=0).**
  - The grant goes to the first channel with in_valid set, searching from index ptr upward and wrapping from N-1 to 0.
  - If no channel is valid, there is no grant.
- **Fixed grant (mode=1).**
  - The grant goes to fixed_sel only if in_valid[fixed_sel] is set; otherwise there is no grant.
  - Other channels are never granted in this mode.
- **in_ready.** in_ready[g] = accept && grant==g && !reset. All other bits are 0.
- **Transfer.** A transfer happens on channel g when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
- **Drain without refill.** If out_valid && out_ready and there is no grant, out_valid <= 0. out_data and out_sel hold their last values.
- **Stall.** If out_valid && !out_ready, out_data, out_sel and out_valid hold, and all in_ready bits are 0.
- **Pointer update.**
  - Only a round-robin transfer updates ptr: ptr <= (g+1) mod N, wrapping naturally at SELW bits.
  - Fixed-mode transfers leave ptr unchanged.
- **Mode changes.** mode and fixed_sel are combinational into the grant, so a change takes effect in the same cycle. Returning to mode=0 resumes arbitration from the retained ptr.
- **Input ordering.** Channels need not hold in_valid until accepted (no stability assumption is made). The block never drops or duplicates an accepted word.

## Timing
- **Reset.**
  - While reset is high, in_ready = 0.
  - On the first edge with reset high: out_valid=0, out_data=0, out_sel=0, ptr=0.
  - Reset asserted mid-operation discards any undelivered output word at the next edge.
- **Latency.** 1 cycle: a word accepted at edge k appears on out_data, with out_valid=1, after edge k.
- **Throughput.** 1 word per cycle while out_ready=1 and any eligible channel is valid.
- **Simultaneous drain and load.** When out_valid && out_ready and a grant exists in the same cycle, the output is replaced with no bubble.
- **Combinational paths.** in_valid, mode, fixed_sel and out_ready reach in_ready combinationally. There are no combinational paths to out_data, out_valid or out_sel.
- **Fairness.** In mode=0 with all N channels continuously valid and out_ready=1, every channel is granted exactly once in any N consecutive transfers.

## Test plan
- **Reset.** Assert reset for 2 cycles with all in_valid=1.
  - During reset: in_ready=0.
  - After reset: out_valid=0, out_data=0, out_sel=0.
  - First transfer goes to channel 0.
- **Full round-robin.** mode=0, N=4, all channels valid with data 0x10+i, out_ready=1.
  - out_sel sequence 0,1,2,3,0,1 on consecutive cycles.
  - out_data is 0x10..0x13 repeating.
- **Sparse with wrap.** Only channels 0 and 2 valid, with ptr=3 at the start.
  - Grants go 0, 2, 0, 2.
  - in_ready is never high on channels 1 or 3.
- **Backpressure.** out_valid=1 with out_ready=0 for 3 cycles.
  - out_data and out_sel are stable and in_ready=0 throughout.
  - When out_ready rises, the next word loads on that same edge with no bubble.
- **Fixed mode.** mode=1, fixed_sel=3, all channels valid.
  - Only channel 3 is granted, each cycle; ptr is unchanged.
  - Drop in_valid[3]: out_valid goes to 0 after the current word drains.
  - Switch to mode=0: arbitration resumes from the saved ptr.
- **Reset mid-transfer.** out_valid=1 with out_ready=0, then pulse reset.
  - Next edge: out_valid=0, out_data=0, ptr=0.
  - The held word is not delivered afterwards.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: producer-side channels plus consumer-side output bus of rr_arb_mux
interface rr_arb_mux_if #(
  parameter int WIDTH = 64,
  parameter int N = 4
);
  localparam int SELW = $clog2(N);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic mode;
  logic [SELW-1:0] fixed_sel;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic [SELW-1:0] out_sel;
  logic out_ready;
  modport slave (
    input in_data, in_valid, mode, fixed_sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
  modport master (
    output in_data, in_valid, mode, fixed_sel, out_ready,
    input in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 registered mux with round-robin or fixed-select arbitration
module rr_arb_mux #(
  parameter int WIDTH = 64,
  parameter int N = 4
) (
  input logic clk,
  input logic reset,
  rr_arb_mux_if.slave bus
);
  localparam int SELW = $clog2(N);
  logic [SELW-1:0] ptr_q, ptr_d, out_sel_q, out_sel_d, gnt, idx;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, gnt_vld, xfer;
  always_comb begin
    gnt = bus.fixed_sel;
    gnt_vld = bus.mode && bus.in_valid[bus.fixed_sel];
    idx = '0;
    // descending scan so the valid channel closest to ptr wins last
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_q + SELW'(i);
      if (!bus.mode && bus.in_valid[idx]) begin
        gnt = idx;
        gnt_vld = 1'b1;
      end
    end
    xfer = gnt_vld && (!out_valid_q || bus.out_ready) && !reset;
    out_valid_d = xfer || (out_valid_q && !bus.out_ready);
    out_data_d = xfer ? bus.in_data[int'(gnt)*WIDTH +: WIDTH] : out_data_q;
    out_sel_d = xfer ? gnt : out_sel_q;
    ptr_d = (xfer && !bus.mode) ? gnt + SELW'(1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      out_sel_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      out_sel_q <= out_sel_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.in_ready = xfer ? N'(1) << gnt : '0;
  assign bus.out_data = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: vector table, directed corner sequences and randomized reference-model check
module tb_rr_arb_mux;
  localparam int W = 64;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  rr_arb_mux_if #(.WIDTH(W), .N(N)) bus ();
  rr_arb_mux #(.WIDTH(W), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [3:0] vld;
    logic mode;
    logic [1:0] fsel;
    logic ordy;
    logic [3:0] rdy;
    logic ov;
    logic [1:0] os;
    logic [63:0] od;
  } vec_t;
  vec_t tbl[19];
  int m_ptr;
  logic m_ov;
  logic [1:0] m_os;
  logic [63:0] m_od;
  logic [63:0] d[4];
  logic r, m, o, acc;
  logic [3:0] v, e_rdy;
  logic [1:0] f;
  int g;
  function automatic vec_t mk(logic rst, logic [3:0] vld, logic mode, logic [1:0] fsel, logic ordy,
                              logic [3:0] rdy, logic ov, logic [1:0] os, logic [63:0] od);
    vec_t t;
    t.rst = rst; t.vld = vld; t.mode = mode; t.fsel = fsel; t.ordy = ordy;
    t.rdy = rdy; t.ov = ov; t.os = os; t.od = od;
    return t;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask
  task automatic drive(input logic rr, input logic [3:0] vv, input logic mm, input logic [1:0] ff, input logic oo);
    reset = rr;
    bus.in_valid = vv;
    bus.mode = mm;
    bus.fixed_sel = ff;
    bus.out_ready = oo;
  endtask
  task automatic run(input string tag, input logic [3:0] rdy, input logic ov, input logic [1:0] os, input logic [63:0] od);
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    chk({tag, ".out_sel"}, 64'(bus.out_sel), 64'(os));
    chk({tag, ".out_data"}, bus.out_data, od);
  endtask
  initial begin
    bus.in_data = {64'h13, 64'h12, 64'h11, 64'h10};
    drive(1'b1, 4'hf, 1'b0, 2'd0, 1'b1);
    tbl[0]  = mk(1, 4'hf, 0, 0, 1, 4'h0, 0, 0, 64'h0);
    tbl[1]  = mk(1, 4'hf, 0, 0, 1, 4'h0, 0, 0, 64'h0);
    tbl[2]  = mk(0, 4'hf, 0, 0, 1, 4'h1, 1, 0, 64'h10);
    tbl[3]  = mk(0, 4'hf, 0, 0, 1, 4'h2, 1, 1, 64'h11);
    tbl[4]  = mk(0, 4'hf, 0, 0, 1, 4'h4, 1, 2, 64'h12);
    tbl[5]  = mk(0, 4'hf, 0, 0, 1, 4'h8, 1, 3, 64'h13);
    tbl[6]  = mk(0, 4'hf, 0, 0, 1, 4'h1, 1, 0, 64'h10);
    tbl[7]  = mk(0, 4'hf, 0, 0, 1, 4'h2, 1, 1, 64'h11);
    tbl[8]  = mk(0, 4'h4, 0, 0, 1, 4'h4, 1, 2, 64'h12);
    tbl[9]  = mk(0, 4'h5, 0, 0, 1, 4'h1, 1, 0, 64'h10);
    tbl[10] = mk(0, 4'h5, 0, 0, 1, 4'h4, 1, 2, 64'h12);
    tbl[11] = mk(0, 4'h5, 0, 0, 1, 4'h1, 1, 0, 64'h10);
    tbl[12] = mk(0, 4'h5, 0, 0, 1, 4'h4, 1, 2, 64'h12);
    tbl[13] = mk(0, 4'hf, 1, 3, 1, 4'h8, 1, 3, 64'h13);
    tbl[14] = mk(0, 4'hf, 1, 3, 1, 4'h8, 1, 3, 64'h13);
    tbl[15] = mk(0, 4'h7, 1, 3, 1, 4'h0, 0, 3, 64'h13);
    tbl[16] = mk(0, 4'h7, 1, 3, 1, 4'h0, 0, 3, 64'h13);
    tbl[17] = mk(0, 4'hf, 0, 3, 1, 4'h8, 1, 3, 64'h13);
    tbl[18] = mk(0, 4'hf, 0, 0, 1, 4'h1, 1, 0, 64'h10);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].mode, tbl[i].fsel, tbl[i].ordy);
      run($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ov, tbl[i].os, tbl[i].od);
    end
    // backpressure: word from channel 0 held, then refilled from channel 1 with no bubble
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'hf, 1'b0, 2'd0, 1'b0);
      run($sformatf("stall%0d", i), 4'h0, 1'b1, 2'd0, 64'h10);
    end
    drive(1'b0, 4'hf, 1'b0, 2'd0, 1'b1);
    run("release", 4'h2, 1'b1, 2'd1, 64'h11);
    // reset while a word is stalled: it is discarded and ptr restarts at 0
    drive(1'b0, 4'hf, 1'b0, 2'd0, 1'b0);
    run("pre_rst", 4'h0, 1'b1, 2'd1, 64'h11);
    drive(1'b1, 4'hf, 1'b0, 2'd0, 1'b0);
    run("mid_rst", 4'h0, 1'b0, 2'd0, 64'h0);
    drive(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
    run("post_rst_idle", 4'h0, 1'b0, 2'd0, 64'h0);
    drive(1'b0, 4'hf, 1'b0, 2'd0, 1'b1);
    run("post_rst_first", 4'h1, 1'b1, 2'd0, 64'h10);
    m_ptr = 0; m_ov = 1'b0; m_os = 2'd0; m_od = 64'h0;
    for (int c = 0; c < 3000; c++) begin
      r = (c < 2) || ($urandom_range(99) == 0);
      v = 4'($urandom);
      m = ($urandom_range(3) == 0);
      f = 2'($urandom);
      o = ($urandom_range(9) < 7);
      for (int ch = 0; ch < N; ch++) begin
        d[ch] = {$urandom, $urandom};
        bus.in_data[ch*W +: W] = d[ch];
      end
      drive(r, v, m, f, o);
      acc = !m_ov || o;
      g = -1;
      if (m) g = v[f] ? int'(f) : -1;
      else for (int k = 0; k < N; k++) if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_rdy = (!r && acc && g >= 0) ? 4'(1 << g) : 4'h0;
      if (r) begin
        m_ptr = 0; m_ov = 1'b0; m_os = 2'd0; m_od = 64'h0;
      end else if (e_rdy != 4'h0) begin
        m_od = d[g]; m_os = 2'(g); m_ov = 1'b1;
        if (!m) m_ptr = (g + 1) % N;
      end else if (o) m_ov = 1'b0;
      run($sformatf("rnd%0d", c), e_rdy, m_ov, m_os, m_od);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
